// File: rtl/stall_ctrl_pkg.sv
// Shared encodings and default timing constants for the pipeline stall controller.
package stall_ctrl_pkg;

  localparam logic [1:0] TUSE_NONE       = 2'd3;
  localparam int         MULT_CYCLES_DEF = 5;
  localparam int         DIV_CYCLES_DEF  = 10;
  localparam int         CNT_W_DEF       = 32;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/stall_ctrl_md_busy_timer.sv
// Down-counter tracking the mult/div unit's busy window; busy while count is nonzero.
module md_busy_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] load_val,
  output logic         busy
);

  logic [W-1:0] count;

  // A start while already counting simply reloads (restart).
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (start) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/stall_ctrl.sv
// Hazard/stall controller: Tuse/Tnew compare, mult/div busy stall, stall performance counter.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic [1:0]       D_Tuse_rs,
  input  logic [1:0]       D_Tuse_rt,
  input  logic             D_is_md,
  input  logic [4:0]       E_wa,
  input  logic [1:0]       E_Tnew,
  input  logic [4:0]       M_wa,
  input  logic [1:0]       M_Tnew,
  input  logic             E_md_start,
  input  logic             E_md_is_div,
  output logic             PC_En,
  output logic             FD_En,
  output logic             DE_Clr,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MD_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

  logic [MD_W-1:0] md_load;
  logic            timer_busy;
  logic            stall_rs;
  logic            stall_rt;
  logic            stall_md;
  logic            stall;

  assign md_load = E_md_is_div ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);

  md_busy_timer #(.W(MD_W)) u_md_timer (
    .clk      (clk),
    .reset    (reset),
    .start    (E_md_start),
    .load_val (md_load),
    .busy     (timer_busy)
  );

  // Reset masks busy so the pipeline is never held while reset is asserted.
  assign md_busy = timer_busy & ~reset;

  always_comb begin
    stall_rs = (D_rs != 5'd0) && (D_Tuse_rs != TUSE_NONE) &&
               (((D_rs == E_wa) && (D_Tuse_rs < E_Tnew)) ||
                ((D_rs == M_wa) && (D_Tuse_rs < M_Tnew)));
    stall_rt = (D_rt != 5'd0) && (D_Tuse_rt != TUSE_NONE) &&
               (((D_rt == E_wa) && (D_Tuse_rt < E_Tnew)) ||
                ((D_rt == M_wa) && (D_Tuse_rt < M_Tnew)));
    stall_md = D_is_md && (md_busy || E_md_start);
    stall    = ~reset && (stall_rs || stall_rt || stall_md);
  end

  assign PC_En  = ~stall;
  assign FD_En  = ~stall;
  assign DE_Clr = stall;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench for stall_ctrl: directed scenarios plus randomized traffic vs. a cycle-indexed model.
module tb_stall_ctrl;

  localparam int MULT_N  = 5;
  localparam int DIV_N   = 10;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int EXP_W   = 4 + CNT_W;

  logic             clk;
  logic             reset;
  logic [4:0]       D_rs, D_rt, E_wa, M_wa;
  logic [1:0]       D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic             D_is_md, E_md_start, E_md_is_div;
  logic             PC_En, FD_En, DE_Clr, md_busy;
  logic [CNT_W-1:0] stall_cnt;

  stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .D_rs        (D_rs),
    .D_rt        (D_rt),
    .D_Tuse_rs   (D_Tuse_rs),
    .D_Tuse_rt   (D_Tuse_rt),
    .D_is_md     (D_is_md),
    .E_wa        (E_wa),
    .E_Tnew      (E_Tnew),
    .M_wa        (M_wa),
    .M_Tnew      (M_Tnew),
    .E_md_start  (E_md_start),
    .E_md_is_div (E_md_is_div),
    .PC_En       (PC_En),
    .FD_En       (FD_En),
    .DE_Clr      (DE_Clr),
    .md_busy     (md_busy),
    .stall_cnt   (stall_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard state
  logic [EXP_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // reference model: absolute cycle index, last busy cycle, stall count
  int cyc     = 0;
  int md_last = -1;
  int m_cnt   = 0;

  function automatic bit reg_hazard(input int idx, input int tuse, input int ewa, input int etnew,
                                    input int mwa, input int mtnew);
    if (idx == 0 || tuse == 3) return 1'b0;
    return (idx == ewa && tuse < etnew) || (idx == mwa && tuse < mtnew);
  endfunction

  // driver: applies one cycle of inputs and pushes the expected outputs for that cycle
  task automatic drive(input bit rst, input int rs, input int rt, input int tu_rs, input int tu_rt,
                       input bit is_md, input int ewa, input int etnew, input int mwa,
                       input int mtnew, input bit start, input bit is_div);
    bit busy_now;
    bit stall_now;
    @(posedge clk);
    #1;
    reset       = rst;
    D_rs        = 5'(rs);
    D_rt        = 5'(rt);
    D_Tuse_rs   = 2'(tu_rs);
    D_Tuse_rt   = 2'(tu_rt);
    D_is_md     = is_md;
    E_wa        = 5'(ewa);
    E_Tnew      = 2'(etnew);
    M_wa        = 5'(mwa);
    M_Tnew      = 2'(mtnew);
    E_md_start  = start;
    E_md_is_div = is_div;

    busy_now  = !rst && (cyc <= md_last);
    stall_now = !rst && (reg_hazard(rs, tu_rs, ewa, etnew, mwa, mtnew) ||
                         reg_hazard(rt, tu_rt, ewa, etnew, mwa, mtnew) ||
                         (is_md && (busy_now || start)));
    exp_q.push_back({~stall_now, ~stall_now, stall_now, busy_now, CNT_W'(m_cnt)});

    if (rst) begin
      m_cnt   = 0;
      md_last = cyc;
    end else begin
      if (stall_now && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (start) md_last = cyc + (is_div ? DIV_N : MULT_N);
    end
    cyc = cyc + 1;
  endtask

  task automatic idle(input bit rst, input bit is_md);
    drive(rst, 0, 0, 3, 3, is_md, 0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  // monitor: outputs are presented every cycle; compare mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EXP_W-1:0] e;
      logic [EXP_W-1:0] a;
      e = exp_q.pop_front();
      a = {PC_En, FD_En, DE_Clr, md_busy, stall_cnt};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL outputs t=%0t pc/fd/clr/busy/cnt actual=%b/%b/%b/%b/%0d required=%b/%b/%b/%b/%0d",
                 $time, a[EXP_W-1], a[EXP_W-2], a[EXP_W-3], a[EXP_W-4], a[CNT_W-1:0],
                 e[EXP_W-1], e[EXP_W-2], e[EXP_W-3], e[EXP_W-4], e[CNT_W-1:0]);
      end
    end
  end

  initial begin
    reset = 1'b1;
    D_rs = '0; D_rt = '0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3; D_is_md = 1'b0;
    E_wa = '0; E_Tnew = '0; M_wa = '0; M_Tnew = '0; E_md_start = 1'b0; E_md_is_div = 1'b0;
    @(posedge clk);

    // reset state
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);

    // load-use on rs, then on rt
    drive(0, 8, 0, 0, 3, 0, 8, 2, 0, 0, 0, 0);
    drive(0, 0, 9, 3, 1, 0, 0, 0, 9, 2, 0, 0);
    drive(0, 0, 9, 3, 0, 0, 4, 2, 9, 1, 0, 0);
    // forwardable / unused / zero register
    drive(0, 8, 0, 1, 3, 0, 0, 0, 8, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0);
    drive(0, 8, 8, 3, 3, 0, 8, 2, 8, 1, 0, 0);
    drive(0, 8, 0, 2, 3, 0, 8, 2, 0, 0, 0, 0);

    // mult window with D_is_md held high
    drive(0, 0, 0, 3, 3, 1, 0, 0, 0, 0, 1, 0);
    repeat (7) idle(1'b0, 1'b1);

    // div window, non-md instructions never stall
    drive(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 1);
    repeat (11) idle(1'b0, 1'b0);

    // data stall and md stall together count once
    drive(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 5, 0, 0, 3, 1, 5, 2, 0, 0, 0, 0);
    repeat (5) idle(1'b0, 1'b0);

    // reset mid-div at busy cycle 3
    drive(0, 0, 0, 3, 3, 1, 0, 0, 0, 0, 1, 1);
    repeat (3) idle(1'b0, 1'b1);
    idle(1'b1, 1'b1);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);

    // saturation: 20 cycles of continuous stall
    idle(1'b1, 1'b0);
    repeat (20) drive(0, 8, 0, 0, 3, 0, 8, 2, 0, 0, 0, 0);
    idle(1'b0, 1'b0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 49) == 0,
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 3), $urandom_range(0, 2),
            $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1);
    end

    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
